// File: rtl/rr_arb4_sel.sv
// rtl/rr_arb4_sel.sv - round-robin arbiter for 4 requesters feeding a 2-to-4 decoder
// Grants are held until the owner drops its request, signals DONE, or hits MAX_HOLD.
module rr_arb4_sel #(
  parameter int MAX_HOLD = 16,
  parameter int PTR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] REQ,
  input  logic       DONE,
  output logic [1:0] A,
  output logic       E,
  output logic       TMO
);

  localparam int            CW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
  localparam logic [1:0]    PTR_RST  = 2'(PTR_INIT);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_a, w_a_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_tmo, w_tmo_nxt;
  logic [3:0]    w_rot;
  logic [1:0]    w_off;
  logic [1:0]    w_win;
  logic          w_rel_req;
  logic          w_rel_tmo;

  // Rotate requests so the pointer position lands at bit 0, then priority-encode.
  assign w_rot = 4'({REQ, REQ} >> r_ptr);

  always_comb begin
    w_off = 2'd0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else if (w_rot[3]) w_off = 2'd3;
  end

  assign w_win     = r_ptr + w_off;
  assign w_rel_req = !REQ[r_a] || DONE;
  assign w_rel_tmo = (MAX_HOLD != 0) && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (REQ != 4'b0000) begin
          w_state_nxt = ST_GRANT;
          w_a_nxt     = w_win;
          w_ptr_nxt   = w_win + 2'd1;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (w_rel_req || w_rel_tmo) begin
          w_state_nxt = ST_IDLE;
          w_tmo_nxt   = w_rel_tmo && !w_rel_req;
        end else if ((MAX_HOLD != 0) && (r_cnt != CNT_LAST)) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= 2'b00;
      r_ptr   <= PTR_RST;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  assign A   = r_a;
  assign E   = (r_state == ST_GRANT);
  assign TMO = r_tmo;

endmodule

// File: tb/tb_rr_arb4_sel.sv
// tb/tb_rr_arb4_sel.sv - scoreboard bench for rr_arb4_sel (MAX_HOLD=4, PTR_INIT=0)
module tb_rr_arb4_sel;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic       DONE = 1'b0;
  logic [1:0] A;
  logic       E;
  logic       TMO;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] sb_q[$];
  logic [3:0] exp_v;

  rr_arb4_sel #(.MAX_HOLD(4), .PTR_INIT(0)) dut (
    .clk (clk),
    .rst (rst),
    .REQ (REQ),
    .DONE(DONE),
    .A   (A),
    .E   (E),
    .TMO (TMO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Row layout: {REQ[3:0], DONE, expected E, expected A[1:0], expected TMO}
  function automatic logic [8:0] row(input logic [3:0] req, input logic done,
                                     input logic e, input logic [1:0] a, input logic t);
    return {req, done, e, a, t};
  endfunction

  task automatic do_reset();
    rst  = 1'b1;
    REQ  = 4'b0000;
    DONE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] t [5];
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({E, A, TMO} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: got E/A/TMO=%b required 0000", {E, A, TMO});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) t[i] = row(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < $size(t); i++) begin
      @(negedge clk);
      REQ = t[i][8:5]; DONE = t[i][4]; sb_q.push_back(t[i][3:0]);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      n_tests++;
      if ({E, A, TMO} !== exp_v) begin
        n_fail++;
        $display("FAIL test_reset row %0d: got E/A/TMO=%b required %b", i, {E, A, TMO}, exp_v);
      end
    end
  endtask

  task automatic test_basic_rr();
    logic [8:0] t [5];
    do_reset();
    t = '{row(4'b1010, 1'b0, 1'b1, 2'd1, 1'b0),
          row(4'b1000, 1'b0, 1'b0, 2'd1, 1'b0),
          row(4'b1000, 1'b0, 1'b1, 2'd3, 1'b0),
          row(4'b0000, 1'b0, 1'b0, 2'd3, 1'b0),
          row(4'b0000, 1'b0, 1'b0, 2'd3, 1'b0)};
    for (int i = 0; i < $size(t); i++) begin
      @(negedge clk);
      REQ = t[i][8:5]; DONE = t[i][4]; sb_q.push_back(t[i][3:0]);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      n_tests++;
      if ({E, A, TMO} !== exp_v) begin
        n_fail++;
        $display("FAIL test_basic_rr row %0d: got E/A/TMO=%b required %b", i, {E, A, TMO}, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] t [10];
    do_reset();
    for (int g = 0; g < 5; g++) begin
      t[2*g]   = row(4'b1111, 1'b0, 1'b1, 2'(g), 1'b0);
      t[2*g+1] = row(4'b1111, 1'b1, 1'b0, 2'(g), 1'b0);
    end
    for (int i = 0; i < $size(t); i++) begin
      @(negedge clk);
      REQ = t[i][8:5]; DONE = t[i][4]; sb_q.push_back(t[i][3:0]);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      n_tests++;
      if ({E, A, TMO} !== exp_v) begin
        n_fail++;
        $display("FAIL test_back_to_back row %0d: got E/A/TMO=%b required %b", i, {E, A, TMO}, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    logic [8:0] t [8];
    do_reset();
    t = '{row(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0),
          row(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0),
          row(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0),
          row(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0),
          row(4'b0100, 1'b0, 1'b0, 2'd2, 1'b1),
          row(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0),
          row(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0),
          row(4'b0000, 1'b0, 1'b0, 2'd2, 1'b0)};
    for (int i = 0; i < $size(t); i++) begin
      @(negedge clk);
      REQ = t[i][8:5]; DONE = t[i][4]; sb_q.push_back(t[i][3:0]);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      n_tests++;
      if ({E, A, TMO} !== exp_v) begin
        n_fail++;
        $display("FAIL test_timeout row %0d: got E/A/TMO=%b required %b", i, {E, A, TMO}, exp_v);
      end
    end
  endtask

  task automatic test_fair_timeout();
    logic [8:0] t [7];
    do_reset();
    t = '{row(4'b0101, 1'b0, 1'b1, 2'd0, 1'b0),
          row(4'b1101, 1'b0, 1'b1, 2'd0, 1'b0),
          row(4'b0111, 1'b0, 1'b1, 2'd0, 1'b0),
          row(4'b0101, 1'b0, 1'b1, 2'd0, 1'b0),
          row(4'b0101, 1'b0, 1'b0, 2'd0, 1'b1),
          row(4'b0101, 1'b0, 1'b1, 2'd2, 1'b0),
          row(4'b0000, 1'b0, 1'b0, 2'd2, 1'b0)};
    for (int i = 0; i < $size(t); i++) begin
      @(negedge clk);
      REQ = t[i][8:5]; DONE = t[i][4]; sb_q.push_back(t[i][3:0]);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      n_tests++;
      if ({E, A, TMO} !== exp_v) begin
        n_fail++;
        $display("FAIL test_fair_timeout row %0d: got E/A/TMO=%b required %b", i, {E, A, TMO}, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    REQ = 4'b0100; DONE = 1'b0;
    sb_q.push_back({1'b1, 2'd2, 1'b0});
    @(posedge clk); #1;
    exp_v = sb_q.pop_front();
    n_tests++;
    if ({E, A, TMO} !== exp_v) begin
      n_fail++;
      $display("FAIL async_grant: got E/A/TMO=%b required %b", {E, A, TMO}, exp_v);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({E, A, TMO} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_midcycle: got E/A/TMO=%b required 0000", {E, A, TMO});
    end
    sb_q.push_back(4'b0000);
    @(posedge clk); #1;
    exp_v = sb_q.pop_front();
    n_tests++;
    if ({E, A, TMO} !== exp_v) begin
      n_fail++;
      $display("FAIL async_held: got E/A/TMO=%b required %b", {E, A, TMO}, exp_v);
    end
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back({1'b1, 2'd2, 1'b0});
    @(posedge clk); #1;
    exp_v = sb_q.pop_front();
    n_tests++;
    if ({E, A, TMO} !== exp_v) begin
      n_fail++;
      $display("FAIL async_regrant: got E/A/TMO=%b required %b", {E, A, TMO}, exp_v);
    end
  endtask

  task automatic test_timeout_overlap();
    logic [8:0] t [12];
    for (int v = 0; v < 2; v++) begin
      do_reset();
      for (int i = 0; i < 4; i++) t[6*v+i] = row(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
      t[6*v+4] = (v == 0) ? row(4'b0000, 1'b1, 1'b0, 2'd2, 1'b0)
                          : row(4'b0100, 1'b1, 1'b0, 2'd2, 1'b0);
      t[6*v+5] = row(4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);
      for (int i = 6*v; i < 6*v + 6; i++) begin
        @(negedge clk);
        REQ = t[i][8:5]; DONE = t[i][4]; sb_q.push_back(t[i][3:0]);
        @(posedge clk); #1;
        exp_v = sb_q.pop_front();
        n_tests++;
        if ({E, A, TMO} !== exp_v) begin
          n_fail++;
          $display("FAIL test_timeout_overlap row %0d: got E/A/TMO=%b required %b", i, {E, A, TMO}, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rr();
    test_back_to_back();
    test_timeout();
    test_fair_timeout();
    test_async_reset();
    test_timeout_overlap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
